// File: rtl/dc_bus_pkg.sv
// Shared data-memory bus types: widths, responder FSM states and the byte-lane merge helper.
package dc_bus_pkg;

   localparam int DM_ADDR_W = 32;
   localparam int DM_DATA_W = 64;
   localparam int DM_MASK_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } dm_state_t;

   // Bytes whose mask bit is set come from new_dat, the rest keep old_dat.
   function automatic logic [DM_DATA_W-1:0] merge_bytes(
      input logic [DM_DATA_W-1:0] old_dat,
      input logic [DM_DATA_W-1:0] new_dat,
      input logic [DM_MASK_W-1:0] mask
   );
      logic [DM_DATA_W-1:0] res;
      res = old_dat;
      for (int i = 0; i < DM_MASK_W; i++) begin
         if (mask[i]) res[8*i +: 8] = new_dat[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dm_reg_bank.sv
// DEPTH x 64-bit register bank: byte-masked write port, combinational read port, register 0 read-only.
// Write takes effect at the clock edge; read has zero latency; no backpressure.
module dm_reg_bank
   import dc_bus_pkg::*;
#(
   parameter int                   DEPTH    = 64,
   parameter logic [DM_DATA_W-1:0] ID_VALUE = 64'h0000_0000_5345_4741,
   parameter int                   IDX_W    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_vld,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [DM_DATA_W-1:0] wr_dat,
   input  logic [DM_MASK_W-1:0] wr_mask,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [DM_DATA_W-1:0] rd_dat
);

   logic [DM_DATA_W-1:0] regs [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         regs[0] <= ID_VALUE;
         for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_vld && (wr_idx != '0)) begin
         regs[wr_idx] <= merge_bytes(regs[wr_idx], wr_dat, wr_mask);
      end
   end

   assign rd_dat = regs[rd_idx];

endmodule

// File: rtl/dm_reg_responder.sv
// Register-window responder on the dm_req/dm_resp bus: one transaction at a time, response pulse LATENCY cycles after accept.
// No backpressure: requests are only accepted in IDLE, so the next accept is at least LATENCY+2 cycles later.
module dm_reg_responder
   import dc_bus_pkg::*;
#(
   parameter logic [28:0]          BASE_ADDR = 29'h005f6800,
   parameter int                   DEPTH     = 64,
   parameter int                   LATENCY   = 2,
   parameter logic [DM_DATA_W-1:0] ID_VALUE  = 64'h0000_0000_5345_4741
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sel,
   input  logic [DM_ADDR_W-1:0] dm_req_addr,
   input  logic [DM_DATA_W-1:0] dm_req_wdata,
   input  logic [DM_MASK_W-1:0] dm_req_wmask,
   input  logic                 dm_req_wen,
   input  logic                 dm_req_valid,
   output logic [DM_DATA_W-1:0] dm_resp_rdata,
   output logic                 dm_resp_valid,
   output logic                 busy
);

   localparam int                IDX_W     = $clog2(DEPTH);
   localparam int                CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [28:0]       WIN_BYTES = 29'(DEPTH * 8);
   localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);

   dm_state_t            state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;

   logic [28:0]          offset;
   logic                 hit_rng;
   logic [IDX_W-1:0]     hit_idx;
   logic                 accept;
   logic                 unused_addr;

   logic [IDX_W-1:0]     idx_q;
   logic [DM_DATA_W-1:0] wdat_q;
   logic [DM_MASK_W-1:0] wmask_q;
   logic                 wen_q;
   logic                 rng_q;

   logic                 bank_wr_vld;
   logic [DM_DATA_W-1:0] bank_rd_dat;

   // 29-bit subtraction wraps, so addresses below the base land far out of range.
   assign offset      = dm_req_addr[28:0] - BASE_ADDR;
   assign hit_rng     = offset < WIN_BYTES;
   assign hit_idx     = offset[3 +: IDX_W];
   assign unused_addr = ^dm_req_addr[DM_ADDR_W-1:29];
   assign accept      = (state == IDLE) && sel && dm_req_valid;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt   = CNT_INIT;
               state_nxt = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx_q   <= '0;
         wdat_q  <= '0;
         wmask_q <= '0;
         wen_q   <= 1'b0;
         rng_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            idx_q   <= hit_idx;
            wdat_q  <= dm_req_wdata;
            wmask_q <= dm_req_wmask;
            wen_q   <= dm_req_wen;
            rng_q   <= hit_rng;
         end
      end
   end

   // Write commits on the RESP edge, so a read in the same cycle would still see the old value.
   assign bank_wr_vld = (state == RESP) && wen_q && rng_q;

   dm_reg_bank #(
      .DEPTH    (DEPTH),
      .ID_VALUE (ID_VALUE),
      .IDX_W    (IDX_W)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_vld  (bank_wr_vld),
      .wr_idx  (idx_q),
      .wr_dat  (wdat_q),
      .wr_mask (wmask_q),
      .rd_idx  (idx_q),
      .rd_dat  (bank_rd_dat)
   );

   assign dm_resp_valid = (state == RESP);
   assign dm_resp_rdata = ((state == RESP) && !wen_q && rng_q) ? bank_rd_dat : '0;
   assign busy          = (state != IDLE);

endmodule
